// File: rtl/even_hold_sampler.sv
// Counter-stream reader: keeps the latest even word and checks the stream step.
// Sticky error stalls the stream until cleared.
module even_hold_sampler #(
  parameter int WIDTH = 32,
  parameter int STEP  = 1,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             err_clr,
  output logic [WIDTH-1:0] hold_q,
  output logic             hold_valid,
  output logic [CNT_W-1:0] accept_cnt,
  output logic [CNT_W-1:0] drop_cnt,
  output logic             err,
  output logic [1:0]       state_o
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_HOLD  = 2'd1,
    S_ERROR = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] LP_STEP = WIDTH'(STEP);
  localparam logic [CNT_W-1:0] LP_CMAX = '1;

  state_t           r_state;
  state_t           w_state_nx;
  logic [WIDTH-1:0] r_hold;
  logic [WIDTH-1:0] w_hold_nx;
  logic             r_hv;
  logic             w_hv_nx;
  logic [WIDTH-1:0] r_last;
  logic [WIDTH-1:0] w_last_nx;
  logic [CNT_W-1:0] r_acc;
  logic [CNT_W-1:0] w_acc_nx;
  logic [CNT_W-1:0] r_drop;
  logic [CNT_W-1:0] w_drop_nx;
  logic             r_err;
  logic             w_err_nx;
  logic             w_xfer;
  logic [WIDTH-1:0] w_expect;
  logic             w_seq_bad;

  assign in_ready  = (r_state != S_ERROR);
  assign w_xfer    = in_valid && in_ready;
  assign w_expect  = r_last + LP_STEP;
  // The first word after EMPTY seeds last_seen and is never checked.
  assign w_seq_bad = (r_state == S_HOLD) && (in_data != w_expect);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_EMPTY;
      r_hold  <= '0;
      r_hv    <= 1'b0;
      r_last  <= '0;
      r_acc   <= '0;
      r_drop  <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_hold  <= w_hold_nx;
      r_hv    <= w_hv_nx;
      r_last  <= w_last_nx;
      r_acc   <= w_acc_nx;
      r_drop  <= w_drop_nx;
      r_err   <= w_err_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_hold_nx  = r_hold;
    w_hv_nx    = r_hv;
    w_last_nx  = r_last;
    w_acc_nx   = r_acc;
    w_drop_nx  = r_drop;
    w_err_nx   = r_err;
    unique case (r_state)
      S_EMPTY, S_HOLD: begin
        if (w_xfer) begin
          if (w_seq_bad) begin
            w_state_nx = S_ERROR;
            w_err_nx   = 1'b1;
          end else begin
            w_state_nx = S_HOLD;
            w_last_nx  = in_data;
            if (!in_data[0]) begin
              w_hold_nx = in_data;
              w_hv_nx   = 1'b1;
              if (r_acc != LP_CMAX) w_acc_nx = r_acc + 1'b1;
            end else begin
              if (r_drop != LP_CMAX) w_drop_nx = r_drop + 1'b1;
            end
          end
        end
      end
      S_ERROR: begin
        if (err_clr) begin
          w_state_nx = S_EMPTY;
          w_err_nx   = 1'b0;
        end
      end
      default: w_state_nx = S_EMPTY;
    endcase
  end

  assign hold_q     = r_hold;
  assign hold_valid = r_hv;
  assign accept_cnt = r_acc;
  assign drop_cnt   = r_drop;
  assign err        = r_err;
  assign state_o    = r_state;

endmodule

// File: tb/tb_even_hold_sampler.sv
// Directed bench for even_hold_sampler: a 32-bit/8-bit instance and a
// 4-bit/3-bit instance for wrap and counter saturation.
module tb_even_hold_sampler;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        err_clr = 1'b0;
  logic [31:0] hold_q;
  logic        hold_valid;
  logic [7:0]  accept_cnt;
  logic [7:0]  drop_cnt;
  logic        err;
  logic [1:0]  state_o;

  logic [3:0]  s_data = '0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic        s_clr = 1'b0;
  logic [3:0]  s_hold;
  logic        s_hv;
  logic [2:0]  s_acc;
  logic [2:0]  s_drop;
  logic        s_err;
  logic [1:0]  s_state;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  even_hold_sampler #(.WIDTH(32), .STEP(1), .CNT_W(8)) u_dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .err_clr(err_clr),
    .hold_q(hold_q), .hold_valid(hold_valid),
    .accept_cnt(accept_cnt), .drop_cnt(drop_cnt),
    .err(err), .state_o(state_o)
  );

  even_hold_sampler #(.WIDTH(4), .STEP(1), .CNT_W(3)) u_small (
    .clk(clk), .rst(rst),
    .in_data(s_data), .in_valid(s_valid), .in_ready(s_ready),
    .err_clr(s_clr),
    .hold_q(s_hold), .hold_valid(s_hv),
    .accept_cnt(s_acc), .drop_cnt(s_drop),
    .err(s_err), .state_o(s_state)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    s_valid = 1'b0;
    err_clr = 1'b0;
    s_clr = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    rst = 1'b1;
    #1;
    total++;
    if ({state_o, hold_q, hold_valid, accept_cnt, drop_cnt, err, in_ready}
        !== {2'd0, 32'd0, 1'b0, 8'd0, 8'd0, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL reset_async got st=%0d hq=%0h hv=%0b a=%0d d=%0d e=%0b r=%0b",
               state_o, hold_q, hold_valid, accept_cnt, drop_cnt, err, in_ready);
    end
    tick();
    rst = 1'b0;
  endtask

  task automatic test_stream();
    logic [31:0] exp_h;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      in_data = i;
      in_valid = 1'b1;
      tick();
      exp_h = i & ~32'd1;
      total++;
      if (hold_q !== exp_h) begin
        bad++;
        $display("FAIL stream_hold[%0d] got=%0d exp=%0d", i, hold_q, exp_h);
      end
    end
    in_valid = 1'b0;
    in_data = 32'd55;
    tick();
    total++;
    if ({accept_cnt, drop_cnt, err, hold_q, state_o}
        !== {8'd5, 8'd5, 1'b0, 32'd8, 2'd1}) begin
      bad++;
      $display("FAIL stream_final got a=%0d d=%0d e=%0b hq=%0d st=%0d exp a=5 d=5 e=0 hq=8 st=1",
               accept_cnt, drop_cnt, err, hold_q, state_o);
    end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    total++;
    if ({state_o, err} !== {2'd1, 1'b0}) begin
      bad++;
      $display("FAIL clr_in_hold got st=%0d e=%0b exp st=1 e=0", state_o, err);
    end
  endtask

  task automatic test_error_recover();
    do_reset();
    in_valid = 1'b1;
    in_data = 32'd0;
    tick();
    in_data = 32'd1;
    tick();
    in_data = 32'd3;
    tick();
    total++;
    if ({err, state_o, in_ready, hold_q, accept_cnt, drop_cnt}
        !== {1'b1, 2'd2, 1'b0, 32'd0, 8'd1, 8'd1}) begin
      bad++;
      $display("FAIL seq_err got e=%0b st=%0d r=%0b hq=%0d a=%0d d=%0d exp e=1 st=2 r=0 hq=0 a=1 d=1",
               err, state_o, in_ready, hold_q, accept_cnt, drop_cnt);
    end
    in_data = 32'd2;
    tick();
    in_data = 32'd4;
    tick();
    total++;
    if ({state_o, hold_q, accept_cnt, drop_cnt}
        !== {2'd2, 32'd0, 8'd1, 8'd1}) begin
      bad++;
      $display("FAIL err_ignores got st=%0d hq=%0d a=%0d d=%0d exp st=2 hq=0 a=1 d=1",
               state_o, hold_q, accept_cnt, drop_cnt);
    end
    in_valid = 1'b0;
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    total++;
    if ({state_o, err, in_ready, hold_valid, hold_q, accept_cnt}
        !== {2'd0, 1'b0, 1'b1, 1'b1, 32'd0, 8'd1}) begin
      bad++;
      $display("FAIL err_clear got st=%0d e=%0b r=%0b hv=%0b hq=%0d a=%0d exp st=0 e=0 r=1 hv=1 hq=0 a=1",
               state_o, err, in_ready, hold_valid, hold_q, accept_cnt);
    end
    in_valid = 1'b1;
    in_data = 32'd10;
    tick();
    in_valid = 1'b0;
    total++;
    if ({hold_q, accept_cnt, drop_cnt, state_o, err}
        !== {32'd10, 8'd2, 8'd1, 2'd1, 1'b0}) begin
      bad++;
      $display("FAIL recover_word got hq=%0d a=%0d d=%0d st=%0d e=%0b exp hq=10 a=2 d=1 st=1 e=0",
               hold_q, accept_cnt, drop_cnt, state_o, err);
    end
  endtask

  task automatic test_wrap32();
    do_reset();
    in_valid = 1'b1;
    in_data = 32'hFFFF_FFFE;
    tick();
    in_data = 32'hFFFF_FFFF;
    tick();
    total++;
    if (hold_q !== 32'hFFFF_FFFE) begin
      bad++;
      $display("FAIL wrap32_hold got=%0h exp=fffffffe", hold_q);
    end
    in_data = 32'd0;
    tick();
    in_valid = 1'b0;
    total++;
    if ({hold_q, err, state_o} !== {32'd0, 1'b0, 2'd1}) begin
      bad++;
      $display("FAIL wrap32_zero got hq=%0h e=%0b st=%0d exp hq=0 e=0 st=1",
               hold_q, err, state_o);
    end
  endtask

  task automatic test_wrap_small();
    logic [3:0] words [4];
    logic [3:0] exp_h [4];
    words = '{4'd14, 4'd15, 4'd0, 4'd1};
    exp_h = '{4'd14, 4'd14, 4'd0, 4'd0};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      s_data = words[i];
      s_valid = 1'b1;
      tick();
      total++;
      if ({s_hold, s_err} !== {exp_h[i], 1'b0}) begin
        bad++;
        $display("FAIL wrap4[%0d] got hq=%0d e=%0b exp hq=%0d e=0",
                 i, s_hold, s_err, exp_h[i]);
      end
    end
    s_valid = 1'b0;
  endtask

  task automatic test_saturation();
    do_reset();
    s_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      s_data = 4'(i);
      tick();
      if (i == 13) begin
        total++;
        if ({s_acc, s_drop} !== {3'd7, 3'd7}) begin
          bad++;
          $display("FAIL sat_reach got a=%0d d=%0d exp a=7 d=7", s_acc, s_drop);
        end
      end
    end
    s_valid = 1'b0;
    total++;
    if ({s_acc, s_drop, s_err, s_hold} !== {3'd7, 3'd7, 1'b0, 4'd2}) begin
      bad++;
      $display("FAIL sat_hold got a=%0d d=%0d e=%0b hq=%0d exp a=7 d=7 e=0 hq=2",
               s_acc, s_drop, s_err, s_hold);
    end
  endtask

  task automatic test_reset_midstream();
    do_reset();
    in_valid = 1'b1;
    in_data = 32'd0;
    tick();
    in_data = 32'd2;
    tick();
    total++;
    if ({err, state_o} !== {1'b1, 2'd2}) begin
      bad++;
      $display("FAIL pre_rst_err got e=%0b st=%0d exp e=1 st=2", err, state_o);
    end
    #3;
    rst = 1'b1;
    #1;
    total++;
    if ({state_o, hold_q, hold_valid, accept_cnt, drop_cnt, err, in_ready}
        !== {2'd0, 32'd0, 1'b0, 8'd0, 8'd0, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL rst_mid got st=%0d hq=%0h hv=%0b a=%0d d=%0d e=%0b r=%0b",
               state_o, hold_q, hold_valid, accept_cnt, drop_cnt, err, in_ready);
    end
    in_data = 32'd4;
    tick();
    total++;
    if ({hold_q, accept_cnt, state_o} !== {32'd0, 8'd0, 2'd0}) begin
      bad++;
      $display("FAIL rst_edge_xfer got hq=%0d a=%0d st=%0d exp hq=0 a=0 st=0",
               hold_q, accept_cnt, state_o);
    end
    rst = 1'b0;
    in_data = 32'd7;
    tick();
    total++;
    if ({drop_cnt, accept_cnt, state_o, err} !== {8'd1, 8'd0, 2'd1, 1'b0}) begin
      bad++;
      $display("FAIL post_rst_first got d=%0d a=%0d st=%0d e=%0b exp d=1 a=0 st=1 e=0",
               drop_cnt, accept_cnt, state_o, err);
    end
    in_data = 32'd8;
    tick();
    in_valid = 1'b0;
    total++;
    if ({hold_q, hold_valid, accept_cnt} !== {32'd8, 1'b1, 8'd1}) begin
      bad++;
      $display("FAIL post_rst_next got hq=%0d hv=%0b a=%0d exp hq=8 hv=1 a=1",
               hold_q, hold_valid, accept_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_error_recover();
    test_wrap32();
    test_wrap_small();
    test_saturation();
    test_reset_midstream();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/even_hold_sampler.md
Name: even_hold_sampler

Overview:
- Reader end of a free-running counter stream: consumes words from a synchronous producer over a valid/ready handshake.
- Holds the most recent even-valued word as a registered output, i.e. the synchronous, clocked form of a level-sensitive hold.
- Checks that the stream advances by exactly STEP per transfer and counts accepted and dropped words.
- Sits between a counter/writer block and downstream logic or properties that need a stable, even-only value.

Parameters:
WIDTH, 32, data word width
STEP, 1, required increment between consecutive transferred words (mod 2^WIDTH)
CNT_W, 8, width of the accept/drop counters

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-high
in_data  input  WIDTH  producer word
in_valid  input  1  producer word valid
in_ready  output  1  sampler can accept a word
err_clr  input  1  clears the sticky sequence error
hold_q  output  WIDTH  last accepted even word
hold_valid  output  1  hold_q holds a captured word
accept_cnt  output  CNT_W  even words captured, saturating
drop_cnt  output  CNT_W  odd words discarded, saturating
err  output  1  sticky sequence error
state_o  output  2  current state: 0 EMPTY, 1 HOLD, 2 ERROR

Behaviour:
- One clock: clk. Reset: rst, asynchronous, active-high.
- Reset values, applied immediately on rst with no clock edge needed:
  - state = EMPTY, hold_q = 0, hold_valid = 0.
  - accept_cnt = 0, drop_cnt = 0, err = 0.
  - last_seen (internal) = 0.
  - in_ready = 1.
- Transfer: a rising edge of clk with in_valid = 1 and in_ready = 1. No transfer means no state change apart from err_clr.
- in_ready is 1 in EMPTY and HOLD, 0 in ERROR. It is a combinational decode of state only and has no dependency on in_valid.
- Sequence check: expected = (last_seen + STEP) mod 2^WIDTH.
  - Checked on every transfer in HOLD.
  - Not checked on the first transfer out of EMPTY.
- On a transfer with the check passing, or in EMPTY:
  - last_seen <= in_data.
  - If in_data[0] = 0: hold_q <= in_data, hold_valid <= 1, accept_cnt increments.
  - If in_data[0] = 1: hold_q is unchanged, drop_cnt increments.
  - state <= HOLD.
- On a transfer in HOLD with in_data != expected:
  - state <= ERROR, err <= 1.
  - hold_q, hold_valid, counters and last_seen are all unchanged; the word is discarded.
- Latency: hold_q and the counters reflect a transfer on the next clock edge, one cycle after in_valid is sampled.
- Counters saturate at 2^CNT_W - 1 and never wrap.
- Wrap-around: last_seen = 2^WIDTH - 1 followed by in_data = STEP - 1 is a legal sequence. For STEP = 1 that is all-ones followed by 0.
- ERROR state:
  - No transfers are accepted.
  - err_clr = 1 at an edge: state <= EMPTY, err <= 0.
  - hold_q, hold_valid and counters are retained.
  - The next word is accepted without a sequence check.
- err_clr outside ERROR has no effect.
- An error can only occur in HOLD, so err_clr and an error never coincide at the same edge.
- rst asserted mid-stream, including in ERROR: all state returns to reset values asynchronously. A transfer at the same edge as rst is ignored.
- hold_q never changes to an odd value under any input sequence. Formal property: hold_q[0] == 0 always.
- state_o encoding 3 is unreachable.

Test Plan:
- Words 0..9 on consecutive cycles, in_valid = 1 throughout:
  - hold_q sequence 0,0,2,2,4,4,6,6,8,8, each one cycle after its input.
  - Final accept_cnt = 5, drop_cnt = 5, err = 0.
- Words 0,1,3:
  - err = 1 and state_o = 2 after the edge taking 3; in_ready = 0.
  - hold_q = 0, accept_cnt = 1, drop_cnt = 1.
  - Further valid words are ignored.
- Error recovery from the previous case: pulse err_clr, then send word 10.
  - state_o returns to 0 after the err_clr edge.
  - Word 10 is accepted without a check: hold_q = 10, accept_cnt = 2.
- Wrap with WIDTH = 4, STEP = 1, words 14,15,0,1:
  - No error.
  - hold_q 14,14,0,0.
- Saturation with CNT_W = 3: send 20 consecutive words from 0.
  - accept_cnt = 7 and drop_cnt = 7; neither wraps to 0.
- Reset during a stream of in_valid words: assert rst between edges.
  - All outputs return to reset values before the next clock edge.
  - After release, the first word is accepted with no check.
